sh_frt_multi: RTL and testbench
===============================

Name: sh_frt_multi

Overview:
- Parametrised free-running timer: CNT_W-bit up-counter, NUM_OC output-compare channels, one input-capture channel.
- Generalises the SH7604 FRT, which has a fixed 16-bit counter and two compare registers (A/B), to N channels.
- Adds per-channel output level control and per-channel interrupt lines.
- Sits on the on-chip peripheral bus next to the other SH7604 peripherals; interrupt lines feed the INTC.

Parameters:
- CNT_W, 16, counter/compare/capture width, 8..16.
- NUM_OC, 2, number of output-compare channels, 1..8.
- PRE_DIV0, 8, internal prescale divisor for CKS=00; CKS=01 uses x4, CKS=10 uses x16.

Ports:
- CLK  in  1  system clock
- RST_N  in  1  asynchronous active-low reset
- CE  in  1  clock enable; all state advances only when CE=1
- REG_A  in  5  word register offset (byte address bits [5:1])
- REG_DI  in  16  write data
- REG_WE  in  1  write strobe, one CE cycle
- REG_RD  in  1  read strobe, one CE cycle
- REG_DO  out  16  read data, registered
- FTCI  in  1  external count clock (async)
- FTI  in  1  input-capture pin (async)
- FTO  out  NUM_OC  compare output pins
- IRQ_OC  out  NUM_OC  compare-match interrupt, level
- IRQ_OV  out  1  overflow interrupt, level
- IRQ_IC  out  1  input-capture interrupt, level

Behaviour:
- Register map (word offsets). Unused bits read 0; writes to them are ignored.
  - 0x00 TIER: [0] OVIE, [k+1] OCIE[k], [15] ICIE.
  - 0x01 FTCSR: [0] CCLRA, [1] OVF, [k+2] OCF[k], [15] ICF.
  - 0x02 FRC.
  - 0x03 TCR: [1:0] CKS, [7] IEDG.
  - 0x04 FICR, read-only.
  - 0x05 TOCR: [k] OLVL[k].
  - 0x08+k OCR[k].
- Reset values: FRC=0, OCR[k]=all ones, FICR=0, TIER=0, FTCSR=0, TCR=0, TOCR=0, FTO=0, REG_DO=0, all IRQ=0, prescaler=0.
- Width rules: FRC/OCR/FICR occupy bits [CNT_W-1:0]; upper bits read 0.
- Prescaler: free-running counter on CE.
  - CKS 00/01/10 produce a one-cycle tick every PRE_DIV0, 4*PRE_DIV0 or 16*PRE_DIV0 CE cycles.
  - CKS=11: tick on FTCI rising edge after a 2-FF synchroniser, so 3 CE cycles of latency.
  - Writing TCR resets the prescaler to 0.
- Count: on tick, FRC <= FRC+1, wrapping from all ones to 0.
- Overflow: the wrap sets OVF in the same cycle the count becomes 0.
- Compare: on tick, if FRC (pre-increment value) == OCR[k]:
  - set OCF[k];
  - FTO[k] <= OLVL[k];
  - if k==0 and CCLRA=1, FRC <= 0 instead of incrementing, and OVF is not set.
  - Several channels may match in the same tick; each is handled independently.
- Input capture: FTI passes through a 2-FF synchroniser; edge detection picks the rising edge when IEDG=1, falling when IEDG=0.
  - On the selected edge, FICR <= FRC and ICF sets.
  - Total latency: 3 CE cycles from the pin edge.
- Flags (OVF, OCF, ICF) are write-0-to-clear; writing 1 has no effect. CCLRA is plain R/W.
- Same cycle set and clear: set wins, flag stays 1.
- CPU write to FRC in the same cycle as a tick: the written value wins, and no compare or overflow is evaluated for that tick.
- Write to OCR[k] in the same cycle as a matching tick: the compare uses the old OCR value.
- Capture edge in the same cycle as an FRC write: FICR takes the pre-write FRC value.
- Reads: REG_DO is valid the cycle after REG_RD and holds until the next read.
- Interrupts: IRQ_* = flag & enable, registered; asserted the cycle after the flag sets.
- Reset mid-count: all state returns to reset values immediately (async); synchronisers clear to 0.

Test Plan:
- Reset, then read all registers -> OCR=0xFFFF, FRC=0, TCR=0, FTCSR=0, FTO=0, IRQs low.
- CKS=00, PRE_DIV0=8, 80 CE cycles -> FRC=10.
- OCR0=5, OLVL0=1, OCIE0=1, CCLRA=1 -> OCF0 and FTO[0]=1 on the tick with FRC=5; FRC then reads 0; IRQ_OC[0]=1 the next cycle.
- Write FTCSR with OCF0=0 -> IRQ_OC[0]=0.
- FRC written 0xFFFE, OVIE=1 -> after 2 ticks FRC=0, OVF=1, IRQ_OV=1.
- Same test with CCLRA=1 and OCR0=0xFFFF -> FRC clears to 0 and OVF stays 0.
- IEDG=0, FRC=0x1234 steady, drive FTI falling edge -> FICR=0x1234 and ICF=1 three cycles later.
- Rising edge with IEDG=0 -> no capture.
- Flag clear write coinciding with a new compare match -> flag reads 1.
- FRC write coinciding with a tick -> FRC equals the written value.

Source files
------------

// File: rtl/sh_frt_multi.sv
// Free-running timer: CNT_W-bit up-counter, NUM_OC output-compare channels and one
// input-capture channel on a 16-bit word-addressed register bus, clock-enabled by CE.
module sh_frt_multi #(
  parameter int CNT_W    = 16,
  parameter int NUM_OC   = 2,
  parameter int PRE_DIV0 = 8
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic              CE,
  input  logic [4:0]        REG_A,
  input  logic [15:0]       REG_DI,
  input  logic              REG_WE,
  input  logic              REG_RD,
  output logic [15:0]       REG_DO,
  input  logic              FTCI,
  input  logic              FTI,
  output logic [NUM_OC-1:0] FTO,
  output logic [NUM_OC-1:0] IRQ_OC,
  output logic              IRQ_OV,
  output logic              IRQ_IC
);

  localparam int PRE_W = $clog2(16 * PRE_DIV0) + 1;

  localparam logic [4:0] A_TIER  = 5'h00;
  localparam logic [4:0] A_FTCSR = 5'h01;
  localparam logic [4:0] A_FRC   = 5'h02;
  localparam logic [4:0] A_TCR   = 5'h03;
  localparam logic [4:0] A_FICR  = 5'h04;
  localparam logic [4:0] A_TOCR  = 5'h05;
  localparam logic [4:0] A_OCR0  = 5'h08;

  logic [CNT_W-1:0]  frc_q,  frc_d;
  logic [CNT_W-1:0]  ocr_q [NUM_OC];
  logic [CNT_W-1:0]  ocr_d [NUM_OC];
  logic [CNT_W-1:0]  ficr_q, ficr_d;
  logic              ovie_q, ovie_d;
  logic              icie_q, icie_d;
  logic [NUM_OC-1:0] ocie_q, ocie_d;
  logic              cclra_q, cclra_d;
  logic              ovf_q, ovf_d;
  logic              icf_q, icf_d;
  logic [NUM_OC-1:0] ocf_q, ocf_d;
  logic [1:0]        cks_q, cks_d;
  logic              iedg_q, iedg_d;
  logic [NUM_OC-1:0] olvl_q, olvl_d;
  logic [NUM_OC-1:0] fto_q, fto_d;
  logic [NUM_OC-1:0] irq_oc_q, irq_oc_d;
  logic              irq_ov_q, irq_ov_d;
  logic              irq_ic_q, irq_ic_d;
  logic [15:0]       do_q, do_d;
  logic [PRE_W-1:0]  pre_q, pre_d;
  logic [2:0]        ftci_sync_q, ftci_sync_d;
  logic [2:0]        fti_sync_q, fti_sync_d;

  logic              wr_s, rd_s;
  logic              tier_we_s, ftcsr_we_s, frc_we_s, tcr_we_s, tocr_we_s;
  logic [PRE_W-1:0]  period_s;
  logic              tick_s, eval_s, clr_s, wrap_s, cap_s;
  logic [NUM_OC-1:0] match_s;
  logic [15:0]       rdata_s;
  logic              unused_s;

  assign wr_s       = CE & REG_WE;
  assign rd_s       = CE & REG_RD;
  assign tier_we_s  = wr_s & (REG_A == A_TIER);
  assign ftcsr_we_s = wr_s & (REG_A == A_FTCSR);
  assign frc_we_s   = wr_s & (REG_A == A_FRC);
  assign tcr_we_s   = wr_s & (REG_A == A_TCR);
  assign tocr_we_s  = wr_s & (REG_A == A_TOCR);
  assign unused_s   = &{1'b0, REG_DI};

  // Prescaler period select and count tick source
  always_comb begin
    case (cks_q)
      2'b00:   period_s = PRE_W'(PRE_DIV0 - 1);
      2'b01:   period_s = PRE_W'(4 * PRE_DIV0 - 1);
      default: period_s = PRE_W'(16 * PRE_DIV0 - 1);
    endcase
    tick_s = (cks_q == 2'b11) ? (ftci_sync_q[1] & ~ftci_sync_q[2]) : (pre_q == period_s);
    pre_d  = (tcr_we_s || (pre_q == period_s)) ? {PRE_W{1'b0}} : pre_q + PRE_W'(1);
    ftci_sync_d = {ftci_sync_q[1:0], FTCI};
    fti_sync_d  = {fti_sync_q[1:0], FTI};
  end

  // Counter, compare, overflow and capture next state; a CPU write to FRC masks the tick
  always_comb begin
    eval_s = tick_s & ~frc_we_s;
    for (int k = 0; k < NUM_OC; k++) begin
      match_s[k] = eval_s & (frc_q == ocr_q[k]);
    end
    clr_s  = match_s[0] & cclra_q;
    wrap_s = eval_s & ~clr_s & (frc_q == {CNT_W{1'b1}});
    cap_s  = iedg_q ? (fti_sync_q[1] & ~fti_sync_q[2]) : (~fti_sync_q[1] & fti_sync_q[2]);

    if (frc_we_s) begin
      frc_d = REG_DI[CNT_W-1:0];
    end else if (clr_s) begin
      frc_d = {CNT_W{1'b0}};
    end else if (eval_s) begin
      frc_d = frc_q + CNT_W'(1);
    end else begin
      frc_d = frc_q;
    end

    ficr_d = cap_s ? frc_q : ficr_q;
    for (int k = 0; k < NUM_OC; k++) begin
      ocr_d[k] = (wr_s && (REG_A == A_OCR0 + 5'(k))) ? REG_DI[CNT_W-1:0] : ocr_q[k];
      fto_d[k] = match_s[k] ? olvl_q[k] : fto_q[k];
    end
  end

  // Control registers and write-0-to-clear flags; a same-cycle set beats the clear
  always_comb begin
    ovie_d  = tier_we_s ? REG_DI[0] : ovie_q;
    ocie_d  = tier_we_s ? REG_DI[NUM_OC:1] : ocie_q;
    icie_d  = tier_we_s ? REG_DI[15] : icie_q;
    cclra_d = ftcsr_we_s ? REG_DI[0] : cclra_q;
    cks_d   = tcr_we_s ? REG_DI[1:0] : cks_q;
    iedg_d  = tcr_we_s ? REG_DI[7] : iedg_q;
    olvl_d  = tocr_we_s ? REG_DI[NUM_OC-1:0] : olvl_q;

    if (ftcsr_we_s) begin
      ovf_d = (ovf_q & REG_DI[1]) | wrap_s;
      ocf_d = (ocf_q & REG_DI[NUM_OC+1:2]) | match_s;
      icf_d = (icf_q & REG_DI[15]) | cap_s;
    end else begin
      ovf_d = ovf_q | wrap_s;
      ocf_d = ocf_q | match_s;
      icf_d = icf_q | cap_s;
    end

    irq_oc_d = ocf_q & ocie_q;
    irq_ov_d = ovf_q & ovie_q;
    irq_ic_d = icf_q & icie_q;
  end

  // Read data mux; unimplemented bits and addresses return zero
  always_comb begin
    rdata_s = 16'h0000;
    case (REG_A)
      A_TIER: begin
        rdata_s[0]        = ovie_q;
        rdata_s[NUM_OC:1] = ocie_q;
        rdata_s[15]       = icie_q;
      end
      A_FTCSR: begin
        rdata_s[0]          = cclra_q;
        rdata_s[1]          = ovf_q;
        rdata_s[NUM_OC+1:2] = ocf_q;
        rdata_s[15]         = icf_q;
      end
      A_FRC:  rdata_s = 16'(frc_q);
      A_TCR: begin
        rdata_s[1:0] = cks_q;
        rdata_s[7]   = iedg_q;
      end
      A_FICR: rdata_s = 16'(ficr_q);
      A_TOCR: rdata_s[NUM_OC-1:0] = olvl_q;
      default: begin
        for (int k = 0; k < NUM_OC; k++) begin
          if (REG_A == A_OCR0 + 5'(k)) begin
            rdata_s = 16'(ocr_q[k]);
          end else begin
            rdata_s = rdata_s;
          end
        end
      end
    endcase
    do_d = rd_s ? rdata_s : do_q;
  end

  // State registers; everything advances only on CE
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      frc_q       <= {CNT_W{1'b0}};
      ficr_q      <= {CNT_W{1'b0}};
      for (int k = 0; k < NUM_OC; k++) ocr_q[k] <= {CNT_W{1'b1}};
      ovie_q      <= 1'b0;
      icie_q      <= 1'b0;
      ocie_q      <= {NUM_OC{1'b0}};
      cclra_q     <= 1'b0;
      ovf_q       <= 1'b0;
      icf_q       <= 1'b0;
      ocf_q       <= {NUM_OC{1'b0}};
      cks_q       <= 2'b00;
      iedg_q      <= 1'b0;
      olvl_q      <= {NUM_OC{1'b0}};
      fto_q       <= {NUM_OC{1'b0}};
      irq_oc_q    <= {NUM_OC{1'b0}};
      irq_ov_q    <= 1'b0;
      irq_ic_q    <= 1'b0;
      do_q        <= 16'h0000;
      pre_q       <= {PRE_W{1'b0}};
      ftci_sync_q <= 3'b000;
      fti_sync_q  <= 3'b000;
    end else if (CE) begin
      frc_q       <= frc_d;
      ficr_q      <= ficr_d;
      for (int k = 0; k < NUM_OC; k++) ocr_q[k] <= ocr_d[k];
      ovie_q      <= ovie_d;
      icie_q      <= icie_d;
      ocie_q      <= ocie_d;
      cclra_q     <= cclra_d;
      ovf_q       <= ovf_d;
      icf_q       <= icf_d;
      ocf_q       <= ocf_d;
      cks_q       <= cks_d;
      iedg_q      <= iedg_d;
      olvl_q      <= olvl_d;
      fto_q       <= fto_d;
      irq_oc_q    <= irq_oc_d;
      irq_ov_q    <= irq_ov_d;
      irq_ic_q    <= irq_ic_d;
      do_q        <= do_d;
      pre_q       <= pre_d;
      ftci_sync_q <= ftci_sync_d;
      fti_sync_q  <= fti_sync_d;
    end
  end

  assign REG_DO = do_q;
  assign FTO    = fto_q;
  assign IRQ_OC = irq_oc_q;
  assign IRQ_OV = irq_ov_q;
  assign IRQ_IC = irq_ic_q;

endmodule

// File: tb/tb_sh_frt_multi.sv
// Directed bench for sh_frt_multi (defaults CNT_W=16, NUM_OC=2, PRE_DIV0=8).
// Inputs change on the falling edge; outputs are sampled on the falling edge.
module tb_sh_frt_multi;

  localparam logic [4:0] A_TIER  = 5'h00;
  localparam logic [4:0] A_FTCSR = 5'h01;
  localparam logic [4:0] A_FRC   = 5'h02;
  localparam logic [4:0] A_TCR   = 5'h03;
  localparam logic [4:0] A_FICR  = 5'h04;
  localparam logic [4:0] A_TOCR  = 5'h05;
  localparam logic [4:0] A_OCR0  = 5'h08;
  localparam logic [4:0] A_OCR1  = 5'h09;

  logic        CLK = 1'b0;
  logic        RST_N = 1'b0;
  logic        CE = 1'b1;
  logic [4:0]  REG_A = 5'h00;
  logic [15:0] REG_DI = 16'h0000;
  logic        REG_WE = 1'b0;
  logic        REG_RD = 1'b0;
  logic [15:0] REG_DO;
  logic        FTCI = 1'b0;
  logic        FTI = 1'b0;
  logic [1:0]  FTO;
  logic [1:0]  IRQ_OC;
  logic        IRQ_OV;
  logic        IRQ_IC;

  int errors = 0;
  int checks = 0;
  logic [15:0] rd;

  sh_frt_multi #(.CNT_W(16), .NUM_OC(2), .PRE_DIV0(8)) dut (
    .CLK(CLK), .RST_N(RST_N), .CE(CE), .REG_A(REG_A), .REG_DI(REG_DI),
    .REG_WE(REG_WE), .REG_RD(REG_RD), .REG_DO(REG_DO), .FTCI(FTCI), .FTI(FTI),
    .FTO(FTO), .IRQ_OC(IRQ_OC), .IRQ_OV(IRQ_OV), .IRQ_IC(IRQ_IC)
  );

  always #5 CLK = ~CLK;

  // Called at a falling edge; the write lands on the next rising edge.
  task automatic reg_write(input logic [4:0] a, input logic [15:0] d);
    REG_A = a; REG_DI = d; REG_WE = 1'b1;
    @(negedge CLK);
    REG_WE = 1'b0;
  endtask

  task automatic reg_read(input logic [4:0] a, output logic [15:0] d);
    REG_A = a; REG_RD = 1'b1;
    @(negedge CLK);
    REG_RD = 1'b0;
    d = REG_DO;
  endtask

  // One external count pulse; returns just after the edge that applies the tick.
  task automatic ext_tick();
    FTCI = 1'b1;
    @(negedge CLK);
    FTCI = 1'b0;
    @(negedge CLK);
    @(negedge CLK);
  endtask

  task automatic test_reset();
    RST_N = 1'b0;
    repeat (2) @(negedge CLK);
    checks++; if (REG_DO !== 16'h0000) begin errors++; $display("FAIL rst_do: got %h exp 0000", REG_DO); end
    checks++; if (FTO !== 2'b00) begin errors++; $display("FAIL rst_fto: got %b exp 00", FTO); end
    checks++; if ({IRQ_OC, IRQ_OV, IRQ_IC} !== 4'b0000) begin errors++; $display("FAIL rst_irq: got %b exp 0000", {IRQ_OC, IRQ_OV, IRQ_IC}); end
    RST_N = 1'b1;
    reg_read(A_FRC, rd);
    checks++; if (rd !== 16'h0000) begin errors++; $display("FAIL rst_frc: got %h exp 0000", rd); end
    reg_read(A_OCR0, rd);
    checks++; if (rd !== 16'hFFFF) begin errors++; $display("FAIL rst_ocr0: got %h exp ffff", rd); end
    reg_read(A_OCR1, rd);
    checks++; if (rd !== 16'hFFFF) begin errors++; $display("FAIL rst_ocr1: got %h exp ffff", rd); end
    reg_read(A_TCR, rd);
    checks++; if (rd !== 16'h0000) begin errors++; $display("FAIL rst_tcr: got %h exp 0000", rd); end
    reg_read(A_FTCSR, rd);
    checks++; if (rd !== 16'h0000) begin errors++; $display("FAIL rst_ftcsr: got %h exp 0000", rd); end
    reg_read(A_FICR, rd);
    checks++; if (rd !== 16'h0000) begin errors++; $display("FAIL rst_ficr: got %h exp 0000", rd); end
  endtask

  task automatic test_prescale();
    reg_write(A_TCR, 16'h0000);      // prescaler cleared here (edge 0)
    reg_write(A_FRC, 16'h0000);
    repeat (82) @(negedge CLK);
    reg_read(A_FRC, rd);             // ticks at edges 8..80 -> 10
    checks++; if (rd !== 16'h000A) begin errors++; $display("FAIL div8_frc: got %h exp 000a", rd); end
    repeat (5) @(negedge CLK);
    checks++; if (REG_DO !== 16'h000A) begin errors++; $display("FAIL do_hold: got %h exp 000a", REG_DO); end
  endtask

  task automatic test_cks_ce();
    reg_write(A_TCR, 16'h0001);      // divide by 32
    reg_write(A_FRC, 16'h0000);
    repeat (30) @(negedge CLK);
    CE = 1'b0;
    repeat (40) @(negedge CLK);
    CE = 1'b1;
    repeat (15) @(negedge CLK);
    reg_read(A_FRC, rd);             // 47 enabled cycles -> one tick
    checks++; if (rd !== 16'h0001) begin errors++; $display("FAIL div32_ce_frc: got %h exp 0001", rd); end
  endtask

  task automatic test_compare();
    reg_write(A_TCR, 16'h0003);
    reg_write(A_TOCR, 16'h0001);
    reg_write(A_TIER, 16'h0002);
    reg_write(A_OCR0, 16'h0005);
    reg_write(A_FTCSR, 16'h0001);
    reg_write(A_FRC, 16'h0003);
    ext_tick();
    ext_tick();
    checks++; if (FTO !== 2'b00) begin errors++; $display("FAIL cmp_fto_pre: got %b exp 00", FTO); end
    ext_tick();
    checks++; if (FTO !== 2'b01) begin errors++; $display("FAIL cmp_fto: got %b exp 01", FTO); end
    checks++; if (IRQ_OC !== 2'b00) begin errors++; $display("FAIL cmp_irq_early: got %b exp 00", IRQ_OC); end
    @(negedge CLK);
    checks++; if (IRQ_OC !== 2'b01) begin errors++; $display("FAIL cmp_irq: got %b exp 01", IRQ_OC); end
    reg_read(A_FRC, rd);
    checks++; if (rd !== 16'h0000) begin errors++; $display("FAIL cmp_clr_frc: got %h exp 0000", rd); end
    reg_read(A_FTCSR, rd);
    checks++; if (rd !== 16'h0005) begin errors++; $display("FAIL cmp_ftcsr: got %h exp 0005", rd); end
  endtask

  task automatic test_flag_clear();
    reg_write(A_FTCSR, 16'h0001);
    @(negedge CLK);
    checks++; if (IRQ_OC !== 2'b00) begin errors++; $display("FAIL clr_irq: got %b exp 00", IRQ_OC); end
    reg_write(A_FTCSR, 16'h8006);
    reg_read(A_FTCSR, rd);
    checks++; if (rd !== 16'h0000) begin errors++; $display("FAIL w1_noeffect: got %h exp 0000", rd); end
  endtask

  task automatic test_overflow();
    reg_write(A_TIER, 16'h0001);
    reg_write(A_FRC, 16'hFFFE);
    ext_tick();
    ext_tick();
    reg_read(A_FRC, rd);
    checks++; if (rd !== 16'h0000) begin errors++; $display("FAIL ovf_frc: got %h exp 0000", rd); end
    reg_read(A_FTCSR, rd);           // OVF plus OCF1 (OCR1 = ffff)
    checks++; if (rd !== 16'h000A) begin errors++; $display("FAIL ovf_ftcsr: got %h exp 000a", rd); end
    checks++; if (IRQ_OV !== 1'b1) begin errors++; $display("FAIL ovf_irq: got %b exp 1", IRQ_OV); end
    reg_write(A_FTCSR, 16'h0000);
  endtask

  task automatic test_cclra_ovf();
    reg_write(A_TOCR, 16'h0000);
    reg_write(A_OCR0, 16'hFFFF);
    reg_write(A_FTCSR, 16'h0001);
    reg_write(A_FRC, 16'hFFFE);
    ext_tick();
    ext_tick();
    reg_read(A_FRC, rd);
    checks++; if (rd !== 16'h0000) begin errors++; $display("FAIL cclra_frc: got %h exp 0000", rd); end
    reg_read(A_FTCSR, rd);           // CCLRA, OCF0, OCF1, no OVF
    checks++; if (rd !== 16'h000D) begin errors++; $display("FAIL cclra_ftcsr: got %h exp 000d", rd); end
    checks++; if (IRQ_OV !== 1'b0) begin errors++; $display("FAIL cclra_irq_ov: got %b exp 0", IRQ_OV); end
    checks++; if (FTO !== 2'b00) begin errors++; $display("FAIL cclra_fto: got %b exp 00", FTO); end
    reg_write(A_FTCSR, 16'h0000);
  endtask

  task automatic test_capture();
    reg_write(A_TIER, 16'h8000);
    reg_write(A_FRC, 16'h1234);
    FTI = 1'b1;
    repeat (4) @(negedge CLK);
    reg_read(A_FTCSR, rd);
    checks++; if (rd !== 16'h0000) begin errors++; $display("FAIL cap_rise_ignored: got %h exp 0000", rd); end
    FTI = 1'b0;
    @(negedge CLK);
    @(negedge CLK);
    reg_read(A_FTCSR, rd);           // sampled on the third edge: not yet visible
    checks++; if (rd !== 16'h0000) begin errors++; $display("FAIL cap_latency: got %h exp 0000", rd); end
    reg_read(A_FTCSR, rd);
    checks++; if (rd !== 16'h8000) begin errors++; $display("FAIL cap_icf: got %h exp 8000", rd); end
    reg_read(A_FICR, rd);
    checks++; if (rd !== 16'h1234) begin errors++; $display("FAIL cap_ficr: got %h exp 1234", rd); end
    checks++; if (IRQ_IC !== 1'b1) begin errors++; $display("FAIL cap_irq: got %b exp 1", IRQ_IC); end
    reg_write(A_FTCSR, 16'h0000);
    reg_write(A_TIER, 16'h0000);
  endtask

  task automatic test_set_clear_collision();
    reg_write(A_TOCR, 16'h0001);
    reg_write(A_OCR0, 16'h0010);
    reg_write(A_FRC, 16'h0010);
    FTCI = 1'b1;
    @(negedge CLK);
    FTCI = 1'b0;
    @(negedge CLK);
    reg_write(A_FTCSR, 16'h0000);    // lands with the matching tick
    reg_read(A_FTCSR, rd);
    checks++; if (rd !== 16'h0004) begin errors++; $display("FAIL setclr_ocf: got %h exp 0004", rd); end
    checks++; if (FTO !== 2'b01) begin errors++; $display("FAIL setclr_fto: got %b exp 01", FTO); end
  endtask

  task automatic test_frc_write_tick();
    reg_write(A_FTCSR, 16'h0000);
    reg_write(A_OCR0, 16'h0011);     // would match FRC=0011 on the tick
    FTCI = 1'b1;
    @(negedge CLK);
    FTCI = 1'b0;
    @(negedge CLK);
    reg_write(A_FRC, 16'h0100);
    reg_read(A_FRC, rd);
    checks++; if (rd !== 16'h0100) begin errors++; $display("FAIL frcw_tick_frc: got %h exp 0100", rd); end
    reg_read(A_FTCSR, rd);
    checks++; if (rd !== 16'h0000) begin errors++; $display("FAIL frcw_tick_nocmp: got %h exp 0000", rd); end
  endtask

  task automatic test_ocr_write_tick();
    reg_write(A_OCR0, 16'h0100);
    FTCI = 1'b1;
    @(negedge CLK);
    FTCI = 1'b0;
    @(negedge CLK);
    reg_write(A_OCR0, 16'h0200);     // old value 0100 still compares
    reg_read(A_FTCSR, rd);
    checks++; if (rd !== 16'h0004) begin errors++; $display("FAIL ocrw_tick_ocf: got %h exp 0004", rd); end
    reg_read(A_OCR0, rd);
    checks++; if (rd !== 16'h0200) begin errors++; $display("FAIL ocrw_tick_ocr: got %h exp 0200", rd); end
  endtask

  task automatic test_capture_frc_write();
    reg_write(A_FTCSR, 16'h0000);
    reg_write(A_TCR, 16'h0083);      // external clock, rising-edge capture
    FTI = 1'b1;
    @(negedge CLK);
    @(negedge CLK);
    reg_write(A_FRC, 16'h0777);      // same edge as the capture
    reg_read(A_FICR, rd);
    checks++; if (rd !== 16'h0101) begin errors++; $display("FAIL capw_ficr: got %h exp 0101", rd); end
    reg_read(A_FRC, rd);
    checks++; if (rd !== 16'h0777) begin errors++; $display("FAIL capw_frc: got %h exp 0777", rd); end
    reg_read(A_FTCSR, rd);
    checks++; if (rd !== 16'h8000) begin errors++; $display("FAIL capw_icf: got %h exp 8000", rd); end
  endtask

  task automatic test_reset_mid();
    checks++; if (FTO !== 2'b01) begin errors++; $display("FAIL pre_rst_fto: got %b exp 01", FTO); end
    #2 RST_N = 1'b0;
    #1;
    checks++; if (REG_DO !== 16'h0000) begin errors++; $display("FAIL midrst_do: got %h exp 0000", REG_DO); end
    checks++; if (FTO !== 2'b00) begin errors++; $display("FAIL midrst_fto: got %b exp 00", FTO); end
    @(negedge CLK);
    RST_N = 1'b1;
    reg_read(A_OCR0, rd);
    checks++; if (rd !== 16'hFFFF) begin errors++; $display("FAIL midrst_ocr0: got %h exp ffff", rd); end
    reg_read(A_FICR, rd);
    checks++; if (rd !== 16'h0000) begin errors++; $display("FAIL midrst_ficr: got %h exp 0000", rd); end
    reg_read(A_TOCR, rd);
    checks++; if (rd !== 16'h0000) begin errors++; $display("FAIL midrst_tocr: got %h exp 0000", rd); end
  endtask

  initial begin
    @(negedge CLK);
    test_reset();
    test_prescale();
    test_cks_ce();
    test_compare();
    test_flag_clear();
    test_overflow();
    test_cclra_ovf();
    test_capture();
    test_set_clear_collision();
    test_frc_write_tick();
    test_ocr_write_tick();
    test_capture_frc_write();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
